// File: rtl/regfile_sb.sv
// regfile_sb: GPR file plus HI/LO pair, with combinational write-through reads
// and a per-register pending-write scoreboard for issue-stage hazard detection.
module regfile_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int CW       = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs,
  input  logic [AW-1:0]   rt,
  input  logic            rs_used,
  input  logic            rt_used,
  output logic [DW-1:0]   busA,
  output logic [DW-1:0]   busB,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [DW-1:0]   wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [DW-1:0]   wd1,
  input  logic            iss_valid,
  input  logic            iss_rd_we,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_hilo,
  input  logic            hilo_we,
  input  logic [2*DW-1:0] hilo_wd,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic            flush,
  output logic [DW-1:0]   hi_out,
  output logic [DW-1:0]   lo_out,
  output logic            hazard,
  output logic            hilo_busy,
  output logic            sb_full
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW-1:0] CONE  = CW'(1);

  logic [DW-1:0] regs_q [DEPTH];
  logic [DW-1:0] regs_d [DEPTH];
  logic [CW-1:0] cnt_q  [DEPTH];
  logic [CW-1:0] cnt_d  [DEPTH];
  logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0] cnt_hl_q, cnt_hl_d;
  logic [DEPTH-1:0] inc_r, dec_r;
  logic          inc_hl, dec_hl;
  logic          pend_rs, pend_rt;

  // Read ports: later assignments override earlier ones, giving
  // zero-reg > port 0 > port 1 > array priority.
  always_comb begin
    busA = regs_q[rs];
    if (we1 && wa1 == rs) busA = wd1;
    if (we0 && wa0 == rs) busA = wd0;
    if (ZERO_REG && rs == '0) busA = '0;
    busB = regs_q[rt];
    if (we1 && wa1 == rt) busB = wd1;
    if (we0 && wa0 == rt) busB = wd0;
    if (ZERO_REG && rt == '0) busB = '0;
  end

  // HI/LO bypass; the bypassed value is also exactly the next stored value.
  always_comb begin
    hi_out = hi_q;
    lo_out = lo_q;
    if (hilo_we) begin
      hi_out = hilo_wd[2*DW-1:DW];
      lo_out = hilo_wd[DW-1:0];
    end
    if (hi_we) hi_out = wd0;
    if (lo_we) lo_out = wd0;
    hi_d = hi_out;
    lo_d = lo_out;
  end

  // Next GPR contents: port 0 overrides port 1 on an address collision.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
      if (we1 && wa1 == AW'(r)) regs_d[r] = wd1;
      if (we0 && wa0 == AW'(r)) regs_d[r] = wd0;
      if (ZERO_REG && r == 0) regs_d[r] = '0;
    end
  end

  // Per-register issue (increment) and retire (decrement) strobes.
  always_comb begin
    inc_r = '0;
    dec_r = '0;
    for (int r = 0; r < DEPTH; r++) begin
      inc_r[r] = iss_valid && iss_rd_we && iss_rd == AW'(r) && !(ZERO_REG && r == 0);
      dec_r[r] = we0 && wa0 == AW'(r);
    end
    inc_hl = iss_valid && iss_hilo;
    dec_hl = hilo_we;
  end

  // Saturating pending counters; flush clears everything and beats issue.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush)
        cnt_d[r] = '0;
      else if (inc_r[r] && !dec_r[r] && cnt_q[r] != CMAX)
        cnt_d[r] = cnt_q[r] + CONE;
      else if (dec_r[r] && !inc_r[r] && cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - CONE;
    end
    cnt_hl_d = cnt_hl_q;
    if (flush)
      cnt_hl_d = '0;
    else if (inc_hl && !dec_hl && cnt_hl_q != CMAX)
      cnt_hl_d = cnt_hl_q + CONE;
    else if (dec_hl && !inc_hl && cnt_hl_q != '0)
      cnt_hl_d = cnt_hl_q - CONE;
  end

  // Hazard and stall flags; a producer retiring now is covered by the bypass.
  always_comb begin
    pend_rs   = (cnt_q[rs] > CONE) || (cnt_q[rs] == CONE && !(we0 && wa0 == rs));
    pend_rt   = (cnt_q[rt] > CONE) || (cnt_q[rt] == CONE && !(we0 && wa0 == rt));
    hazard    = (rs_used && pend_rs) || (rt_used && pend_rt);
    hilo_busy = (cnt_hl_q != '0) && !(cnt_hl_q == CONE && hilo_we);
    sb_full   = iss_valid && ((iss_rd_we && cnt_q[iss_rd] == CMAX) ||
                              (iss_hilo && cnt_hl_q == CMAX));
  end

  // State registers with synchronous reset of data and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_hl_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_hl_q <= cnt_hl_d;
    end
  end

endmodule
